fact_accel_q: RTL and testbench

Parametrised factorial accelerator, successor to the single-operand factorial slave. Sits on the system bus as a memory-mapped slave and computes n! for a queue of operands instead of one at a time. Results go into a result FIFO with a per-result overflow flag. A level interrupt is raised when the whole batch completes.

---
 rtl/fact_accel_q.sv | 233 +++++++++++++++++++++++
 tb/tb_fact_accel_q.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fact_accel_q.sv
// Memory-mapped factorial accelerator: an operand queue feeds a sequential
// DATA_W x OP_W multiplier whose results land in a FIFO with per-entry overflow.
module fact_accel_q #(
    parameter int DATA_W     = 64,
    parameter int OP_W       = 8,
    parameter int OPQ_DEPTH  = 4,
    parameter int RESQ_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_sel,
    input  logic              s_wr,
    input  logic [7:0]        s_addr,
    input  logic [DATA_W-1:0] s_din,
    output logic [DATA_W-1:0] s_dout,
    output logic              interrupt
);

    localparam int OPA_W = $clog2(OPQ_DEPTH);
    localparam int RSA_W = $clog2(RESQ_DEPTH);
    localparam int PROD_W = DATA_W + OP_W;

    localparam logic [2:0] R_OPSTART = 3'd0;
    localparam logic [2:0] R_OPCLEAR = 3'd1;
    localparam logic [2:0] R_STATUS  = 3'd2;
    localparam logic [2:0] R_INTR_EN = 3'd3;
    localparam logic [2:0] R_OPERAND = 3'd4;
    localparam logic [2:0] R_QCOUNT  = 3'd5;
    localparam logic [2:0] R_RESULT  = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_MUL,
        ST_WRITE
    } state_t;

    state_t              state_q, state_d;
    logic                run_q, run_d;
    logic                done_q, done_d;
    logic                intr_en_q, intr_en_d;
    logic                drop_err_q, drop_err_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [OP_W-1:0]     cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
    logic [OPA_W:0]      opq_wr_ptr_q, opq_wr_ptr_d;
    logic [OPA_W:0]      opq_rd_ptr_q, opq_rd_ptr_d;
    logic [RSA_W:0]      resq_wr_ptr_q, resq_wr_ptr_d;
    logic [RSA_W:0]      resq_rd_ptr_q, resq_rd_ptr_d;

    logic [OP_W-1:0]     opq_mem [OPQ_DEPTH];
    logic [DATA_W:0]     resq_mem [RESQ_DEPTH];

    logic                bus_wr, bus_rd;
    logic [2:0]          reg_idx;
    logic                wr_start, wr_clear, wr_inten, wr_operand, rd_result;
    logic                opq_push, opq_pop, resq_push, resq_pop;
    logic [OPA_W:0]      opq_count;
    logic [RSA_W:0]      resq_count;
    logic                opq_empty, opq_full, resq_empty, resq_full;
    logic [DATA_W:0]     res_head;
    logic                head_ovf;
    logic                busy;
    logic [PROD_W-1:0]   product;
    logic                unused_ok;

    assign bus_wr     = s_sel & s_wr;
    assign bus_rd     = s_sel & ~s_wr;
    assign reg_idx    = s_addr[5:3];
    assign wr_start   = bus_wr && (reg_idx == R_OPSTART) && s_din[0];
    assign wr_clear   = bus_wr && (reg_idx == R_OPCLEAR) && s_din[0];
    assign wr_inten   = bus_wr && (reg_idx == R_INTR_EN);
    assign wr_operand = bus_wr && (reg_idx == R_OPERAND);
    assign rd_result  = bus_rd && (reg_idx == R_RESULT);

    // Extra MSB on each pointer separates full from empty when indices match.
    assign opq_count  = opq_wr_ptr_q - opq_rd_ptr_q;
    assign resq_count = resq_wr_ptr_q - resq_rd_ptr_q;
    assign opq_empty  = (opq_wr_ptr_q == opq_rd_ptr_q);
    assign opq_full   = (opq_wr_ptr_q[OPA_W] != opq_rd_ptr_q[OPA_W]) &&
                        (opq_wr_ptr_q[OPA_W-1:0] == opq_rd_ptr_q[OPA_W-1:0]);
    assign resq_empty = (resq_wr_ptr_q == resq_rd_ptr_q);
    assign resq_full  = (resq_wr_ptr_q[RSA_W] != resq_rd_ptr_q[RSA_W]) &&
                        (resq_wr_ptr_q[RSA_W-1:0] == resq_rd_ptr_q[RSA_W-1:0]);

    assign res_head   = resq_mem[resq_rd_ptr_q[RSA_W-1:0]];
    assign head_ovf   = ~resq_empty & res_head[DATA_W];
    assign busy       = (state_q != ST_IDLE) | run_q;
    assign product    = {{OP_W{1'b0}}, acc_q} * {{DATA_W{1'b0}}, cnt_q};
    assign interrupt  = done_q & intr_en_q;
    assign unused_ok  = &{1'b0, s_addr[7:6], s_addr[2:0], s_din};

    always_comb begin
        state_d    = state_q;
        run_d      = run_q;
        done_d     = done_q;
        intr_en_d  = intr_en_q;
        drop_err_d = drop_err_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        opq_push   = 1'b0;
        opq_pop    = 1'b0;
        resq_push  = 1'b0;
        resq_pop   = 1'b0;

        if (wr_inten) begin
            intr_en_d = s_din[0];
        end
        if (wr_start && !run_q) begin
            run_d  = 1'b1;
            done_d = 1'b0;
        end
        if (wr_operand) begin
            if (opq_full) begin
                drop_err_d = 1'b1;
            end else begin
                opq_push = 1'b1;
            end
        end
        if (rd_result && !resq_empty) begin
            resq_pop = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (run_q) begin
                    if (opq_empty) begin
                        run_d  = 1'b0;
                        done_d = 1'b1;
                    end else if (!resq_full) begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                opq_pop = 1'b1;
                acc_d   = {{(DATA_W-1){1'b0}}, 1'b1};
                cnt_d   = opq_mem[opq_rd_ptr_q[OPA_W-1:0]];
                ovf_d   = 1'b0;
                state_d = ST_MUL;
            end
            ST_MUL: begin
                if (cnt_q <= {{(OP_W-1){1'b0}}, 1'b1}) begin
                    state_d = ST_WRITE;
                end else begin
                    acc_d = product[DATA_W-1:0];
                    ovf_d = ovf_q | (|product[PROD_W-1:DATA_W]);
                    cnt_d = cnt_q - {{(OP_W-1){1'b0}}, 1'b1};
                end
            end
            ST_WRITE: begin
                resq_push = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A flush overrides every queue movement, including a same-cycle WRITE.
        if (wr_clear) begin
            state_d    = ST_IDLE;
            run_d      = 1'b0;
            done_d     = 1'b0;
            drop_err_d = 1'b0;
            opq_push   = 1'b0;
            opq_pop    = 1'b0;
            resq_push  = 1'b0;
            resq_pop   = 1'b0;
        end

        opq_wr_ptr_d  = wr_clear ? '0 : opq_wr_ptr_q + {{OPA_W{1'b0}}, opq_push};
        opq_rd_ptr_d  = wr_clear ? '0 : opq_rd_ptr_q + {{OPA_W{1'b0}}, opq_pop};
        resq_wr_ptr_d = wr_clear ? '0 : resq_wr_ptr_q + {{RSA_W{1'b0}}, resq_push};
        resq_rd_ptr_d = wr_clear ? '0 : resq_rd_ptr_q + {{RSA_W{1'b0}}, resq_pop};
    end

    always_comb begin
        s_dout = '0;
        if (bus_rd) begin
            case (reg_idx)
                R_STATUS:  s_dout = DATA_W'({drop_err_q, head_ovf, opq_full,
                                             ~resq_empty, done_q, busy});
                R_INTR_EN: s_dout = DATA_W'(intr_en_q);
                R_QCOUNT:  s_dout = DATA_W'({8'(resq_count), 8'(opq_count)});
                R_RESULT:  s_dout = resq_empty ? '0 : res_head[DATA_W-1:0];
                default:   s_dout = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            run_q         <= 1'b0;
            done_q        <= 1'b0;
            intr_en_q     <= 1'b0;
            drop_err_q    <= 1'b0;
            acc_q         <= '0;
            cnt_q         <= '0;
            ovf_q         <= 1'b0;
            opq_wr_ptr_q  <= '0;
            opq_rd_ptr_q  <= '0;
            resq_wr_ptr_q <= '0;
            resq_rd_ptr_q <= '0;
        end else begin
            state_q       <= state_d;
            run_q         <= run_d;
            done_q        <= done_d;
            intr_en_q     <= intr_en_d;
            drop_err_q    <= drop_err_d;
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
            ovf_q         <= ovf_d;
            opq_wr_ptr_q  <= opq_wr_ptr_d;
            opq_rd_ptr_q  <= opq_rd_ptr_d;
            resq_wr_ptr_q <= resq_wr_ptr_d;
            resq_rd_ptr_q <= resq_rd_ptr_d;
        end
    end

    // Storage arrays carry no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (opq_push) begin
            opq_mem[opq_wr_ptr_q[OPA_W-1:0]] <= s_din[OP_W-1:0];
        end
        if (resq_push) begin
            resq_mem[resq_wr_ptr_q[RSA_W-1:0]] <= {ovf_q, acc_q};
        end
    end

endmodule

// File: tb/tb_fact_accel_q.sv
// Bench for fact_accel_q: table vectors, directed multi-cycle sequences and
// random batches checked against an arithmetic factorial model.
module tb_fact_accel_q;

    localparam logic [7:0] A_START  = 8'h00;
    localparam logic [7:0] A_CLEAR  = 8'h08;
    localparam logic [7:0] A_STATUS = 8'h10;
    localparam logic [7:0] A_INTEN  = 8'h18;
    localparam logic [7:0] A_OPER   = 8'h20;
    localparam logic [7:0] A_QCNT   = 8'h28;
    localparam logic [7:0] A_RES    = 8'h30;

    logic        clk = 1'b0;
    logic        reset;
    logic        s_sel;
    logic        s_wr;
    logic [7:0]  s_addr;
    logic [63:0] s_din;
    logic [63:0] s_dout;
    logic        interrupt;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0]  op;
        logic [63:0] val;
        logic        ovf;
    } vec_t;

    vec_t vecs[8];

    fact_accel_q #(
        .DATA_W(64), .OP_W(8), .OPQ_DEPTH(4), .RESQ_DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset), .s_sel(s_sel), .s_wr(s_wr),
        .s_addr(s_addr), .s_din(s_din), .s_dout(s_dout), .interrupt(interrupt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // All bus tasks start and end on a falling clock edge.
    task automatic bus_wr(input logic [7:0] a, input logic [63:0] d);
        s_sel = 1'b1; s_wr = 1'b1; s_addr = a; s_din = d;
        @(negedge clk);
        s_sel = 1'b0; s_wr = 1'b0;
    endtask

    task automatic bus_rd(input logic [7:0] a, output logic [63:0] d);
        s_sel = 1'b1; s_wr = 1'b0; s_addr = a;
        #1 d = s_dout;
        @(negedge clk);
        s_sel = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_done(input string name, input int budget);
        logic [63:0] d;
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            bus_rd(A_STATUS, d);
            if (d[1]) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, 64'(ok), 64'd1);
    endtask

    // n! mod 2^64, and whether the exact n! reaches 2^64.
    function automatic void ref_fact(input int n, output logic [63:0] v, output logic o);
        longint unsigned p, exact, k;
        p = 1; exact = 1; o = 1'b0;
        for (int i = 2; i <= n; i++) begin
            k = longint'(i);
            p = p * k;
            if (!o) begin
                if (exact > 64'hFFFF_FFFF_FFFF_FFFF / k) o = 1'b1;
                else exact = exact * k;
            end
        end
        v = p;
    endfunction

    initial begin
        logic [63:0] d;
        logic [63:0] exp_v;
        logic        exp_o;
        logic [63:0] exp_vq[$];
        logic        exp_oq[$];
        int c_op, c_res, c_irq, viol, prev_op, prev_res, cur_op, cur_res, nb;
        bit seen_done;

        vecs[0] = '{8'd0,  64'd1, 1'b0};
        vecs[1] = '{8'd1,  64'd1, 1'b0};
        vecs[2] = '{8'd2,  64'd2, 1'b0};
        vecs[3] = '{8'd3,  64'd6, 1'b0};
        vecs[4] = '{8'd5,  64'd120, 1'b0};
        vecs[5] = '{8'd12, 64'd479001600, 1'b0};
        vecs[6] = '{8'd20, 64'd2432902008176640000, 1'b0};
        vecs[7] = '{8'd21, 64'hC507_7D36_B8C4_0000, 1'b1};

        s_sel = 1'b0; s_wr = 1'b0; s_addr = A_QCNT; s_din = '0; reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_dout_nosel", s_dout, 64'd0);
        check("rst_irq", 64'(interrupt), 64'd0);
        bus_rd(A_STATUS, d); check("rst_status", d, 64'd0);
        bus_rd(A_QCNT, d);   check("rst_qcount", d, 64'd0);
        bus_rd(A_INTEN, d);  check("rst_inten", d, 64'd0);

        // Single operand 5 with interrupt latency
        bus_wr(A_INTEN, 64'd1);
        bus_wr(A_OPER, 64'd5);
        bus_wr(A_START, 64'd1);
        c_op = -1; c_res = -1; c_irq = -1;
        s_sel = 1'b1; s_wr = 1'b0; s_addr = A_QCNT;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (c_op < 0 && s_dout[7:0] == 8'd0) c_op = i;
            if (c_res < 0 && s_dout[15:8] == 8'd1) c_res = i;
            if (c_irq < 0 && interrupt) c_irq = i;
            @(negedge clk);
        end
        s_sel = 1'b0;
        check("irq_seen", 64'(c_irq >= 0), 64'd1);
        check("irq_after_load", 64'(c_irq - c_op), 64'd7);
        check("push_after_load", 64'(c_res - c_op), 64'd6);
        bus_rd(A_STATUS, d); check("f5_ovf", 64'(d[4]), 64'd0);
        bus_rd(A_RES, d);    check("f5_value", d, 64'd120);
        bus_wr(A_CLEAR, 64'd1);
        check("irq_cleared", 64'(interrupt), 64'd0);

        // Batch 0,1,3,10 with count tracking
        bus_wr(A_OPER, 64'd0); bus_wr(A_OPER, 64'd1);
        bus_wr(A_OPER, 64'd3); bus_wr(A_OPER, 64'd10);
        bus_rd(A_QCNT, d); check("batch_qcount_pre", d, 64'h0004);
        bus_wr(A_START, 64'd1);
        viol = 0; seen_done = 1'b0; prev_op = 4; prev_res = 0;
        s_sel = 1'b1; s_wr = 1'b0; s_addr = A_QCNT;
        for (int i = 0; i < 80; i++) begin
            #1;
            cur_op = int'(s_dout[7:0]); cur_res = int'(s_dout[15:8]);
            if (cur_op > prev_op || cur_res < prev_res) viol++;
            if (cur_op + cur_res != 4 && cur_op + cur_res != 3) viol++;
            if (interrupt && cur_res != 4) viol++;
            prev_op = cur_op; prev_res = cur_res;
            if (interrupt) begin
                seen_done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        s_sel = 1'b0;
        check("batch_done", 64'(seen_done), 64'd1);
        check("batch_count_track", 64'(viol), 64'd0);
        bus_rd(A_RES, d); check("batch_r0", d, 64'd1);
        bus_rd(A_RES, d); check("batch_r1", d, 64'd1);
        bus_rd(A_RES, d); check("batch_r2", d, 64'd6);
        bus_rd(A_QCNT, d); check("batch_qcount_mid", d, 64'h0100);
        bus_rd(A_RES, d); check("batch_r3", d, 64'd3628800);
        bus_rd(A_QCNT, d); check("batch_qcount_end", d, 64'h0000);

        // Table-driven single operands
        for (int i = 0; i < 8; i++) begin
            bus_wr(A_OPER, 64'(vecs[i].op));
            bus_wr(A_START, 64'd1);
            wait_done($sformatf("vec%0d_done", i), 400);
            bus_rd(A_STATUS, d);
            check($sformatf("vec%0d_n%0d_ovf", i, vecs[i].op), 64'(d[4]), 64'(vecs[i].ovf));
            bus_rd(A_RES, d);
            check($sformatf("vec%0d_n%0d_val", i, vecs[i].op), d, vecs[i].val);
        end

        // Backpressure with a full result FIFO
        bus_wr(A_OPER, 64'd2); bus_wr(A_OPER, 64'd3);
        bus_wr(A_OPER, 64'd4); bus_wr(A_OPER, 64'd5);
        bus_wr(A_START, 64'd1);
        wait_done("bp_done1", 200);
        bus_wr(A_OPER, 64'd6); bus_wr(A_OPER, 64'd7);
        bus_wr(A_START, 64'd1);
        idle(20);
        bus_rd(A_QCNT, d);   check("bp_stall_qcount", d, 64'h0402);
        bus_rd(A_STATUS, d); check("bp_stall_busy_done", 64'(d[1:0]), 64'd1);
        bus_rd(A_RES, d);    check("bp_r0", d, 64'd2);
        idle(20);
        bus_rd(A_QCNT, d);   check("bp_resume_qcount", d, 64'h0401);
        bus_rd(A_RES, d); check("bp_r1", d, 64'd6);
        bus_rd(A_RES, d); check("bp_r2", d, 64'd24);
        bus_rd(A_RES, d); check("bp_r3", d, 64'd120);
        bus_rd(A_RES, d); check("bp_r4", d, 64'd720);
        wait_done("bp_done2", 200);
        bus_rd(A_RES, d); check("bp_r5", d, 64'd5040);
        bus_rd(A_QCNT, d); check("bp_qcount_end", d, 64'h0000);

        // Operand queue full, then empty-FIFO read
        for (int i = 1; i <= 5; i++) bus_wr(A_OPER, 64'(i));
        bus_rd(A_QCNT, d);   check("qfull_qcount", d, 64'h0004);
        bus_rd(A_STATUS, d); check("qfull_full_drop", d & 64'h28, 64'h28);
        bus_wr(A_CLEAR, 64'd1);
        bus_rd(A_STATUS, d); check("clear_status", d, 64'd0);
        bus_rd(A_RES, d);    check("empty_read", d, 64'd0);
        bus_rd(A_QCNT, d);   check("empty_read_qcount", d, 64'h0000);
        bus_wr(A_OPER, 64'd3);
        bus_wr(A_START, 64'd1);
        wait_done("after_empty_done", 100);
        bus_rd(A_RES, d);    check("after_empty_val", d, 64'd6);
        bus_rd(A_QCNT, d);   check("after_empty_qcount", d, 64'h0000);

        // OPCLEAR aligned with the WRITE of operand 0
        bus_wr(A_OPER, 64'd0);
        bus_wr(A_START, 64'd1);
        idle(3);
        bus_wr(A_CLEAR, 64'd1);
        idle(5);
        bus_rd(A_QCNT, d);   check("clr_write_qcount", d, 64'h0000);
        bus_rd(A_STATUS, d); check("clr_write_status", d, 64'd0);

        // Abort mid-MUL, then reset
        bus_wr(A_OPER, 64'd10);
        bus_wr(A_START, 64'd1);
        idle(4);
        bus_wr(A_CLEAR, 64'd1);
        bus_rd(A_STATUS, d); check("abort_status_idle", d, 64'd0);
        bus_rd(A_INTEN, d);  check("abort_inten_kept", d, 64'd1);
        idle(30);
        bus_rd(A_QCNT, d);   check("abort_no_push", d, 64'h0000);
        check("abort_irq", 64'(interrupt), 64'd0);
        for (int i = 0; i < 5; i++) bus_wr(A_OPER, 64'd4);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst2_irq", 64'(interrupt), 64'd0);
        bus_rd(A_STATUS, d); check("rst2_status", d, 64'd0);
        bus_rd(A_QCNT, d);   check("rst2_qcount", d, 64'd0);
        bus_rd(A_INTEN, d);  check("rst2_inten", d, 64'd0);

        // Random batches against the arithmetic model
        for (int b = 0; b < 8; b++) begin
            nb = int'($urandom_range(1, 4));
            for (int j = 0; j < nb; j++) begin
                int n;
                n = int'($urandom_range(0, 30));
                ref_fact(n, exp_v, exp_o);
                exp_vq.push_back(exp_v);
                exp_oq.push_back(exp_o);
                bus_wr(A_OPER, 64'(n));
            end
            bus_wr(A_START, 64'd1);
            wait_done($sformatf("rnd%0d_done", b), 600);
            while (exp_vq.size() > 0) begin
                exp_v = exp_vq.pop_front();
                exp_o = exp_oq.pop_front();
                bus_rd(A_STATUS, d);
                check($sformatf("rnd%0d_ovf", b), 64'(d[4]), 64'(exp_o));
                bus_rd(A_RES, d);
                check($sformatf("rnd%0d_val", b), d, exp_v);
            end
            bus_rd(A_QCNT, d); check($sformatf("rnd%0d_qcount", b), d, 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
